// File: rtl/sr_reg_bank_if.sv
// Bus bundle for sr_reg_bank: requests and enable in, channel state and conflict status out.
// The q_chg member exists only when SR_BANK_EDGE_EN is defined.
interface sr_reg_bank_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [N-1:0]     s;
    logic [N-1:0]     r;
    logic             clr_err;
    logic [N-1:0]     q;
    logic [N-1:0]     q_n;
    logic [N-1:0]     conflict;
    logic             conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;
`ifdef SR_BANK_EDGE_EN
    logic [N-1:0]     q_chg;
`endif

    modport master (
        output en, s, r, clr_err,
        input  q, q_n, conflict, conflict_sticky, conflict_cnt
`ifdef SR_BANK_EDGE_EN
        , input q_chg
`endif
    );

    modport slave (
        input  en, s, r, clr_err,
        output q, q_n, conflict, conflict_sticky, conflict_cnt
`ifdef SR_BANK_EDGE_EN
        , output q_chg
`endif
    );
endinterface

// File: rtl/sr_reg_bank.sv
// N-channel clocked SR register bank with selectable S=R=1 policy, conflict flags and a saturating counter.
// Optional macro SR_BANK_EDGE_EN adds the registered q_chg change-pulse output.
module sr_reg_bank #(
    parameter int           N       = 8,
    parameter int           MODE    = 0,
    parameter int           CNT_W   = 8,
    parameter logic [N-1:0] RST_VAL = {N{1'b0}}
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_reg_bank_if.slave bus
);

    generate
        if (N < 1 || N > 32) begin : g_bad_n
            $error("sr_reg_bank: N must be in 1..32");
        end
        if (MODE < 0 || MODE > 3) begin : g_bad_mode
            $error("sr_reg_bank: MODE must be in 0..3");
        end
        if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
            $error("sr_reg_bank: CNT_W must be in 2..16");
        end
    endgenerate

    logic [N-1:0]     q_reg;
    logic [N-1:0]     q_nxt;
    logic [N-1:0]     conf_reg;
    logic [N-1:0]     conf_nxt;
    logic             sticky_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             any_conf;

    // Next-state per channel; a disabled bank holds q and drops its requests.
    always_comb begin
        q_nxt    = q_reg;
        conf_nxt = '0;
        if (bus.en) begin
            for (int i = 0; i < N; i++) begin
                case ({bus.s[i], bus.r[i]})
                    2'b01: q_nxt[i] = 1'b0;
                    2'b10: q_nxt[i] = 1'b1;
                    2'b11: begin
                        conf_nxt[i] = 1'b1;
                        case (MODE)
                            0:       q_nxt[i] = 1'b0;
                            1:       q_nxt[i] = 1'b1;
                            3:       q_nxt[i] = ~q_reg[i];
                            default: q_nxt[i] = q_reg[i];
                        endcase
                    end
                    default: q_nxt[i] = q_reg[i];
                endcase
            end
        end
    end

    assign any_conf = |conf_nxt;

    // clr_err wins over a simultaneous conflict for both sticky and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg      <= RST_VAL;
            conf_reg   <= '0;
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            q_reg    <= q_nxt;
            conf_reg <= conf_nxt;
            if (bus.clr_err) begin
                sticky_reg <= 1'b0;
                cnt_reg    <= '0;
            end else if (any_conf) begin
                sticky_reg <= 1'b1;
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.q               = q_reg;
    assign bus.q_n             = ~q_reg;
    assign bus.conflict        = conf_reg;
    assign bus.conflict_sticky = sticky_reg;
    assign bus.conflict_cnt    = cnt_reg;

`ifdef SR_BANK_EDGE_EN
    logic [N-1:0] chg_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_reg <= '0;
        end else begin
            chg_reg <= q_nxt ^ q_reg;
        end
    end

    assign bus.q_chg = chg_reg;
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four instances (MODE 0..3, CNT_W=8) plus a CNT_W=2 instance,
// all sharing one stimulus stream. Covers q_chg when SR_BANK_EDGE_EN is defined.
module tb_sr_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr_err;

    int testsRun;
    int testsFailed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gm
        sr_reg_bank_if #(.N(8), .CNT_W(8)) bus ();
        assign bus.en      = en;
        assign bus.s       = s;
        assign bus.r       = r;
        assign bus.clr_err = clr_err;
        sr_reg_bank #(.N(8), .MODE(g), .CNT_W(8)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    sr_reg_bank_if #(.N(8), .CNT_W(2)) sat_bus ();
    assign sat_bus.en      = en;
    assign sat_bus.s       = s;
    assign sat_bus.r       = r;
    assign sat_bus.clr_err = clr_err;
    sr_reg_bank #(.N(8), .MODE(0), .CNT_W(2)) sat_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sat_bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one input vector, clock it in, then settle away from the edge.
    task automatic applyStimulus(input logic e, input logic [7:0] sv, input logic [7:0] rv, input logic ce);
        en      = e;
        s       = sv;
        r       = rv;
        clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic checkQ(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        checkOutput({tag, " q m0"}, {24'd0, gm[0].bus.q}, {24'd0, e0});
        checkOutput({tag, " q m1"}, {24'd0, gm[1].bus.q}, {24'd0, e1});
        checkOutput({tag, " q m2"}, {24'd0, gm[2].bus.q}, {24'd0, e2});
        checkOutput({tag, " q m3"}, {24'd0, gm[3].bus.q}, {24'd0, e3});
    endtask

    task automatic checkStatus(input string tag, input logic [7:0] conf, input logic sticky, input logic [7:0] cnt);
        checkOutput({tag, " conflict"}, {24'd0, gm[0].bus.conflict}, {24'd0, conf});
        checkOutput({tag, " sticky"}, {31'd0, gm[0].bus.conflict_sticky}, {31'd0, sticky});
        checkOutput({tag, " cnt"}, {24'd0, gm[0].bus.conflict_cnt}, {24'd0, cnt});
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        s       = 8'h00;
        r       = 8'h00;
        clr_err = 1'b0;

        #12;
        checkQ("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("reset q_n", {24'd0, gm[0].bus.q_n}, 32'hFF);
        checkStatus("reset", 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
        #2;

        // Basic set then reset.
        applyStimulus(1'b1, 8'h0F, 8'h00, 1'b0);
        checkQ("set", 8'h0F, 8'h0F, 8'h0F, 8'h0F);
        checkOutput("set q_n", {24'd0, gm[0].bus.q_n}, 32'hF0);
        applyStimulus(1'b1, 8'h00, 8'h03, 1'b0);
        checkQ("rst", 8'h0C, 8'h0C, 8'h0C, 8'h0C);
        checkStatus("rst", 8'h00, 1'b0, 8'h00);

        // Enable gating: requests while disabled are dropped.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0);
            checkOutput("gate q", {24'd0, gm[0].bus.q}, 32'h0C);
        end
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0);
        checkStatus("gate conf", 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0);
        checkQ("ungate", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Conflict policy per MODE starting from q=01.
        applyStimulus(1'b1, 8'h01, 8'hFE, 1'b0);
        checkQ("pre", 8'h01, 8'h01, 8'h01, 8'h01);
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        checkQ("conf1", 8'h00, 8'h01, 8'h01, 8'h00);
        checkStatus("conf1", 8'h01, 1'b1, 8'h01);
        checkOutput("conf1 m3 conflict", {24'd0, gm[3].bus.conflict}, 32'h01);
        checkOutput("conf1 m3 cnt", {24'd0, gm[3].bus.conflict_cnt}, 32'h01);
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        checkQ("conf2", 8'h00, 8'h01, 8'h01, 8'h01);
        checkOutput("conf2 m3 cnt", {24'd0, gm[3].bus.conflict_cnt}, 32'h02);
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        checkQ("conf3", 8'h00, 8'h01, 8'h01, 8'h00);
        checkOutput("conf3 m1 cnt", {24'd0, gm[1].bus.conflict_cnt}, 32'h03);
        checkOutput("conf3 sat cnt", {30'd0, sat_bus.conflict_cnt}, 32'h3);

        // Pulse ends when conflict goes away.
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
        checkStatus("conf end", 8'h00, 1'b1, 8'h03);

        // Asynchronous reset mid-cycle from q=A5.
        applyStimulus(1'b1, 8'hA5, 8'h5A, 1'b0);
        checkQ("preA5", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        checkQ("async", 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("async q_n", {24'd0, gm[0].bus.q_n}, 32'hFF);
        checkStatus("async", 8'h00, 1'b0, 8'h00);
        #3;
        rst_n = 1'b1;

        // Saturation on the CNT_W=2 instance, then clear colliding with a conflict.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0);
            checkOutput("sat cnt", {30'd0, sat_bus.conflict_cnt}, (k < 3) ? (k + 1) : 3);
            checkOutput("wide cnt", {24'd0, gm[0].bus.conflict_cnt}, k + 1);
        end
        checkOutput("sat sticky", {31'd0, sat_bus.conflict_sticky}, 32'd1);
        checkOutput("sat conflict", {24'd0, sat_bus.conflict}, 32'hFF);
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
        checkOutput("clr sat cnt", {30'd0, sat_bus.conflict_cnt}, 32'd0);
        checkOutput("clr sat sticky", {31'd0, sat_bus.conflict_sticky}, 32'd0);
        checkOutput("clr sat conflict", {24'd0, sat_bus.conflict}, 32'hFF);
        checkStatus("clr wide", 8'hFF, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1);
        checkQ("clr keeps q", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

`ifdef SR_BANK_EDGE_EN
        applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
        checkOutput("chg clear", {24'd0, gm[0].bus.q_chg}, 32'hFF);
        applyStimulus(1'b1, 8'h04, 8'h00, 1'b0);
        checkOutput("chg set2", {24'd0, gm[0].bus.q_chg}, 32'h04);
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
        checkOutput("chg hold", {24'd0, gm[0].bus.q_chg}, 32'h00);
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        checkOutput("chg toggle m3", {24'd0, gm[3].bus.q_chg}, 32'h01);
        checkOutput("chg hold m2", {24'd0, gm[2].bus.q_chg}, 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sr_reg_bank.md
Name: sr_reg_bank

Overview:
- N-channel clocked set/reset register bank with a shared enable. It is the synchronous, parametrised successor to the single gated SR latch.
- Conflict handling (S=R=1) is selectable by parameter instead of being left undefined.
- Conflicts are detected, flagged and counted in hardware; no simulation-only messages.
- Used for status/interrupt bit arrays and control flags in the datapath.

Parameters:
- N, 8, number of independent SR channels (1..32).
- MODE, 0, conflict policy:
  - 0 = reset-dominant (q<=0)
  - 1 = set-dominant (q<=1)
  - 2 = hold (q unchanged)
  - 3 = toggle (JK behaviour)
- CNT_W, 8, width of the saturating conflict counter (2..16).
- RST_VAL, {N{1'b0}}, per-channel value of q after reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, global update enable; gates all channels.
- s, input, N, per-channel set request.
- r, input, N, per-channel reset request.
- clr_err, input, 1, synchronous clear of conflict_sticky and conflict_cnt.
- q, output, N, registered channel state.
- q_n, output, N, bitwise inverse of q (combinational from q).
- conflict, output, N, registered per-channel flag: channel saw s=r=1 with en=1 on the previous edge.
- conflict_sticky, output, 1, set when any conflict occurs; held until clr_err.
- conflict_cnt, output, CNT_W, count of cycles with at least one conflicting channel; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - q=RST_VAL, q_n=~RST_VAL.
  - conflict=0, conflict_sticky=0, conflict_cnt=0.
  - Release is sampled synchronously: the first update occurs on the first rising edge with rst_n=1.
- Latency: one cycle. Inputs sampled at edge k appear on q after edge k. No combinational path from s/r/en to q.
- en=0: q holds on every channel; conflict<=0; counter and sticky unchanged. Requests are dropped, not queued.
- en=1, per channel i:
  - s=0,r=0 -> hold.
  - s=0,r=1 -> q[i]<=0.
  - s=1,r=0 -> q[i]<=1.
  - s=1,r=1 -> apply MODE (0: q[i]<=0; 1: q[i]<=1; 2: hold; 3: q[i]<=~q[i]). conflict[i]<=1.
- conflict[i] is 0 on any edge where the conflict condition is false; it is a one-cycle pulse per conflicting edge.
- Counter:
  - Increments by exactly 1 per edge where en=1 and any channel conflicts, regardless of how many channels conflict.
  - Saturates at 2^CNT_W-1; no wrap.
- Sticky: set on the same edge the counter increments.
- clr_err=1 on an edge:
  - conflict_sticky<=0, conflict_cnt<=0.
  - If a conflict occurs on that same edge, clear wins for the counter (result 0) and sticky (result 0).
  - conflict[i] still reports the conflict.
- clr_err has no effect on q.
- Illegal parameter values (MODE>3, N outside range) stop elaboration via a generate-time error.

Optional Feature:
- Macro SR_BANK_EDGE_EN.
- Defined: adds output q_chg[N-1:0], a registered one-cycle pulse on the edge where q[i] changes value. Reset value 0. MODE=3 toggles always pulse; holds never pulse.
- Undefined: port q_chg and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with q=8'hA5, RST_VAL=0 -> q=8'h00, q_n=8'hFF, cnt=0 immediately, without waiting for a clock edge.
- Basic set/reset: en=1, s=8'h0F, r=8'h00, then s=0, r=8'h03 -> q=8'h0F after edge 1, q=8'h0C after edge 2. conflict stays 0.
- Enable gating: en=0, s=8'hFF, r=0 for 3 cycles -> q unchanged, conflict=0, cnt unchanged. Then en=1 for one cycle -> q=8'hFF.
- Conflict per MODE: q=8'h01, en=1, s=r=8'h01 for one cycle. Expected q by MODE: 0 -> 8'h00; 1 -> 8'h01; 2 -> 8'h01; 3 -> 8'h00. Two more cycles in MODE 3 give 8'h01, then 8'h00. In every case conflict=8'h01 and cnt increments by 1 per edge.
- Multi-channel and saturation: CNT_W=2, s=r=8'hFF for 5 cycles -> cnt sequence 1,2,3,3,3, sticky=1. Then clr_err=1 together with one more conflict -> cnt=0, sticky=0, conflict=8'hFF.
- SR_BANK_EDGE_EN defined: q 0->1 on channel 2 -> q_chg=8'h04 for exactly one cycle. A hold on the following cycle -> q_chg=0.
